// File: rtl/hw_sw_comm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hw_sw_comm_pkg
// Purpose  : Shared FSM state type and handshake encodings for the HW->SW
//            message channel.
// Revision : 1.0
// ============================================================================
package hw_sw_comm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        POST    = 2'd1,
        RELEASE = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam logic [1:0] SIG_IDLE = 2'd0;
    localparam logic [1:0] SIG_ACK  = 2'd1;
    localparam logic [1:0] SIG_MSG  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/hw_sw_msg_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick; the search starts at ptr and
//            wraps from N_REQ-1 back to 0.
// Revision : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] grant_idx
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    logic             found;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        found     = 1'b0;
        sum       = '0;
        cand      = '0;
        grant     = '0;
        grant_idx = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            // Extra bit keeps ptr+k from overflowing before the modulo wrap.
            sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N_REQ)) begin
                sum = sum - (IDX_W+1)'(N_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hw_sw_msg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hw_sw_msg_arbiter
// Purpose  : Round-robin sharing of the 2-bit HW->SW message handshake among
//            N_REQ hardware requesters. Optional CPU response timeout is
//            enabled by defining HWSW_ARB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module hw_sw_msg_arbiter
    import hw_sw_comm_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ack,
    input  logic [1:0]                to_hw_sig,
    output logic [1:0]                to_sw_sig,
    output logic [DATA_W-1:0]         msg_data,
    output logic [$clog2(N_REQ)-1:0]  msg_src,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] src_q, src_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic [N_REQ-1:0]  grant;
    logic [IDX_W-1:0]  grant_idx;
    logic [DATA_W-1:0] win_data;
    logic [IDX_W-1:0]  src_next;
    logic              timeout_hit;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr_arbiter (
        .req       (req),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign src_next = (src_q == IDX_W'(N_REQ-1)) ? '0 : src_q + 1'b1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        src_d   = src_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                // A leftover CPU ack must not be mistaken for a response.
                if ((|grant) && (to_hw_sig == SIG_IDLE)) begin
                    state_d = POST;
                    src_d   = grant_idx;
                    data_d  = win_data;
                end
            end
            POST: begin
                if (timeout_hit) begin
                    state_d = IDLE;
                    ptr_d   = src_next;
                end else if (to_hw_sig == SIG_ACK) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (timeout_hit) begin
                    state_d = IDLE;
                    ptr_d   = src_next;
                end else if (to_hw_sig == SIG_IDLE) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                ptr_d   = src_next;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            src_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            src_q   <= src_d;
            data_q  <= data_d;
        end
    end

`ifdef HWSW_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             waiting;

    assign waiting     = (state_q == POST) || (state_q == RELEASE);
    assign timeout_hit = waiting && (cnt_q == CNT_W'(TIMEOUT_CYC-1));

    // Restarts from zero on every state entry so each CPU response gets a full window.
    always_comb begin
        cnt_d = '0;
        if (waiting && (state_d == state_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_err = timeout_hit;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        req_ack = '0;
        if (state_q == DONE) begin
            req_ack[src_q] = 1'b1;
        end
    end

    assign to_sw_sig = (state_q == POST) ? SIG_MSG : SIG_IDLE;
    assign busy      = (state_q != IDLE);
    assign msg_data  = data_q;
    assign msg_src   = src_q;

endmodule
`default_nettype wire

// File: tb/tb_hw_sw_msg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_hw_sw_msg_arbiter
// Purpose  : Scoreboard bench for hw_sw_msg_arbiter (N_REQ=4, DATA_W=8,
//            TIMEOUT_CYC=16).
// Revision : 1.0
// ============================================================================
module tb_hw_sw_msg_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_ack;
    logic [1:0]  to_hw_sig;
    logic [1:0]  to_sw_sig;
    logic [7:0]  msg_data;
    logic [1:0]  msg_src;
    logic        busy;
    logic        timeout_err;

    always #5 clk = ~clk;

    hw_sw_msg_arbiter #(
        .N_REQ       (4),
        .DATA_W      (8),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .req_data    (req_data),
        .req_ack     (req_ack),
        .to_hw_sig   (to_hw_sig),
        .to_sw_sig   (to_sw_sig),
        .msg_data    (msg_data),
        .msg_src     (msg_src),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    typedef struct packed {
        logic [1:0] src;
        logic [7:0] data;
    } post_t;

    post_t      post_q[$];
    logic [3:0] ack_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [1:0] prev_sig = 2'd0;

    // Scoreboard: each new post and each req_ack pulse is matched in order.
    always @(negedge clk) begin : monitor
        post_t      e;
        logic [3:0] a;
        if (reset_n === 1'b1) begin
            if (to_sw_sig === 2'd2 && prev_sig !== 2'd2) begin
                n_checks++;
                if (post_q.size() == 0) begin
                    $display("FAIL post_unexpected: got src=%0d data=%h, none queued", msg_src, msg_data);
                end else begin
                    e = post_q.pop_front();
                    if (msg_src !== e.src || msg_data !== e.data)
                        $display("FAIL post_match: got src=%0d data=%h, want src=%0d data=%h",
                                 msg_src, msg_data, e.src, e.data);
                    else n_pass++;
                end
            end
            if (req_ack !== 4'b0000) begin
                n_checks++;
                if (ack_q.size() == 0) begin
                    $display("FAIL ack_unexpected: got req_ack=%b, none queued", req_ack);
                end else begin
                    a = ack_q.pop_front();
                    if (req_ack !== a)
                        $display("FAIL ack_match: got req_ack=%b, want %b", req_ack, a);
                    else n_pass++;
                end
            end
        end
        prev_sig = to_sw_sig;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_sig(input logic [1:0] v, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (to_sw_sig === v) begin
                ok = 1'b1;
                return;
            end
            tick(1);
        end
        ok = (to_sw_sig === v);
    endtask

    task automatic wait_idle(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                return;
            end
            tick(1);
        end
        ok = (busy === 1'b0);
    endtask

    // CPU side of one transaction, entered while the message is posted.
    task automatic cpu_respond(input int ack_dly, input int idle_dly, output bit ok);
        bit ok1, ok2;
        tick(ack_dly);
        to_hw_sig = 2'd1;
        wait_sig(2'd0, 20, ok1);
        tick(idle_dly);
        to_hw_sig = 2'd0;
        wait_idle(20, ok2);
        tick(1);
        ok = ok1 & ok2;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        req       = 4'b0000;
        req_data  = 32'h0;
        to_hw_sig = 2'd0;
        tick(3);
        n_checks++;
        if (to_sw_sig !== 2'd0 || busy !== 1'b0 || req_ack !== 4'b0)
            $display("FAIL reset_ctrl: sig=%0d busy=%b ack=%b, want 0 0 0000", to_sw_sig, busy, req_ack);
        else n_pass++;
        n_checks++;
        if (msg_data !== 8'h00 || msg_src !== 2'd0 || timeout_err !== 1'b0)
            $display("FAIL reset_data: data=%h src=%0d terr=%b, want 00 0 0", msg_data, msg_src, timeout_err);
        else n_pass++;
        reset_n = 1'b1;
        tick(2);
    endtask

    task automatic test_round_robin();
        bit ok;
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        post_q.push_back({2'd0, 8'h11}); ack_q.push_back(4'b0001);
        post_q.push_back({2'd1, 8'h22}); ack_q.push_back(4'b0010);
        post_q.push_back({2'd2, 8'h33}); ack_q.push_back(4'b0100);
        post_q.push_back({2'd3, 8'h44}); ack_q.push_back(4'b1000);
        post_q.push_back({2'd0, 8'h11}); ack_q.push_back(4'b0001);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_sig(2'd2, 20, ok);
            n_checks++;
            if (!ok) $display("FAIL rr_post_timeout: txn %0d got sig=%0d, want 2", i, to_sw_sig);
            else n_pass++;
            if (i == 4) req = 4'b0000;
            cpu_respond(0, 0, ok);
            n_checks++;
            if (!ok) $display("FAIL rr_cpu_timeout: txn %0d busy=%b, want 0", i, busy);
            else n_pass++;
        end
        tick(3);
        n_checks++;
        if (post_q.size() != 0 || ack_q.size() != 0 || busy !== 1'b0)
            $display("FAIL rr_drain: posts left=%0d acks left=%0d busy=%b, want 0 0 0",
                     post_q.size(), ack_q.size(), busy);
        else n_pass++;
    endtask

    task automatic test_single();
        bit ok;
        req_data = {8'h00, 8'hA5, 8'h00, 8'h00};
        post_q.push_back({2'd2, 8'hA5});
        ack_q.push_back(4'b0100);
        req = 4'b0100;
        tick(1);
        n_checks++;
        if (to_sw_sig !== 2'd2 || busy !== 1'b1)
            $display("FAIL single_latency: sig=%0d busy=%b one cycle after req, want 2 1", to_sw_sig, busy);
        else n_pass++;
        req = 4'b0000;
        tick(3);
        n_checks++;
        if (to_sw_sig !== 2'd2)
            $display("FAIL single_hold: sig=%0d before CPU ack, want 2", to_sw_sig);
        else n_pass++;
        to_hw_sig = 2'd1;
        tick(1);
        n_checks++;
        if (to_sw_sig !== 2'd0 || req_ack !== 4'b0)
            $display("FAIL single_release: sig=%0d ack=%b, want 0 0000", to_sw_sig, req_ack);
        else n_pass++;
        tick(1);
        to_hw_sig = 2'd0;
        wait_idle(10, ok);
        tick(2);
        n_checks++;
        if (!ok || post_q.size() != 0 || ack_q.size() != 0)
            $display("FAIL single_drain: idle=%b posts left=%0d acks left=%0d, want 1 0 0",
                     ok, post_q.size(), ack_q.size());
        else n_pass++;
    endtask

    task automatic test_stale_cpu();
        bit ok;
        bit bad = 1'b0;
        to_hw_sig = 2'd1;
        req_data  = {8'h00, 8'h00, 8'h00, 8'h3C};
        post_q.push_back({2'd0, 8'h3C});
        ack_q.push_back(4'b0001);
        req = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (to_sw_sig !== 2'd0 || busy !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) $display("FAIL stale_hold: sig=%0d busy=%b with stale ack, want 0 0", to_sw_sig, busy);
        else n_pass++;
        to_hw_sig = 2'd0;
        tick(1);
        n_checks++;
        if (to_sw_sig !== 2'd2)
            $display("FAIL stale_post: sig=%0d after CPU idle, want 2", to_sw_sig);
        else n_pass++;
        req = 4'b0000;
        cpu_respond(1, 1, ok);
        n_checks++;
        if (!ok || ack_q.size() != 0)
            $display("FAIL stale_drain: ok=%b acks left=%0d, want 1 0", ok, ack_q.size());
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        bit ok;
        bit bad = 1'b0;
        req_data = {8'h77, 8'h5B, 8'h00, 8'h00};
        post_q.push_back({2'd2, 8'h5B});
        req = 4'b0100;
        wait_sig(2'd2, 10, ok);
        tick(1);
        #1 reset_n = 1'b0;
        #1;
        n_checks++;
        if (!ok || to_sw_sig !== 2'd0 || busy !== 1'b0)
            $display("FAIL midrst_async: posted=%b sig=%0d busy=%b, want 1 0 0", ok, to_sw_sig, busy);
        else n_pass++;
        req = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            if (req_ack !== 4'b0 || to_sw_sig !== 2'd0) bad = 1'b1;
        end
        n_checks++;
        if (bad) $display("FAIL midrst_noack: ack=%b sig=%0d during reset, want 0000 0", req_ack, to_sw_sig);
        else n_pass++;
        reset_n = 1'b1;
        tick(1);
        post_q.push_back({2'd3, 8'h77});
        ack_q.push_back(4'b1000);
        req = 4'b1000;
        wait_sig(2'd2, 10, ok);
        req = 4'b0000;
        n_checks++;
        if (!ok) $display("FAIL midrst_repost: sig=%0d, want 2", to_sw_sig);
        else n_pass++;
        cpu_respond(0, 0, ok);
        n_checks++;
        if (!ok || post_q.size() != 0 || ack_q.size() != 0)
            $display("FAIL midrst_drain: ok=%b posts left=%0d acks left=%0d, want 1 0 0",
                     ok, post_q.size(), ack_q.size());
        else n_pass++;
    endtask

    task automatic test_illegal_and_data();
        bit ok;
        bit bad = 1'b0;
        req_data = {8'h00, 8'h00, 8'h5A, 8'h00};
        post_q.push_back({2'd1, 8'h5A});
        ack_q.push_back(4'b0010);
        req = 4'b0010;
        wait_sig(2'd2, 10, ok);
        req       = 4'b0000;
        to_hw_sig = 2'd3;
        req_data  = {8'h00, 8'h00, 8'hFF, 8'h00};
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (to_sw_sig !== 2'd2 || msg_data !== 8'h5A || msg_src !== 2'd1 || timeout_err !== 1'b0)
                bad = 1'b1;
        end
        n_checks++;
        if (!ok || bad)
            $display("FAIL illegal_hold: sig=%0d data=%h src=%0d, want 2 5a 1", to_sw_sig, msg_data, msg_src);
        else n_pass++;
        to_hw_sig = 2'd0;
        cpu_respond(0, 0, ok);
        n_checks++;
        if (!ok || ack_q.size() != 0)
            $display("FAIL illegal_drain: ok=%b acks left=%0d, want 1 0", ok, ack_q.size());
        else n_pass++;
    endtask

`ifdef HWSW_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        bit bad = 1'b0;
        req_data = {8'hD3, 8'hC2, 8'h00, 8'h00};
        post_q.push_back({2'd2, 8'hC2});
        post_q.push_back({2'd3, 8'hD3});
        ack_q.push_back(4'b1000);
        req = 4'b1100;
        wait_sig(2'd2, 10, ok);
        for (int c = 1; c <= 16; c++) begin
            if (to_sw_sig !== 2'd2 || timeout_err !== (c == 16)) bad = 1'b1;
            tick(1);
        end
        n_checks++;
        if (!ok || bad) $display("FAIL timeout_pulse: sig=%0d terr=%b across 16 POST cycles", to_sw_sig, timeout_err);
        else n_pass++;
        n_checks++;
        if (to_sw_sig !== 2'd0 || busy !== 1'b0 || timeout_err !== 1'b0 || req_ack !== 4'b0)
            $display("FAIL timeout_abort: sig=%0d busy=%b terr=%b ack=%b, want 0 0 0 0000",
                     to_sw_sig, busy, timeout_err, req_ack);
        else n_pass++;
        wait_sig(2'd2, 10, ok);
        req = 4'b0000;
        cpu_respond(0, 0, ok);
        n_checks++;
        if (!ok || post_q.size() != 0 || ack_q.size() != 0)
            $display("FAIL timeout_next: ok=%b posts left=%0d acks left=%0d, want 1 0 0",
                     ok, post_q.size(), ack_q.size());
        else n_pass++;
    endtask
`else
    task automatic test_no_timeout();
        bit ok;
        bit bad = 1'b0;
        req_data = {8'h00, 8'hC3, 8'h00, 8'h00};
        post_q.push_back({2'd2, 8'hC3});
        ack_q.push_back(4'b0100);
        req = 4'b0100;
        wait_sig(2'd2, 10, ok);
        req = 4'b0000;
        for (int c = 0; c < 40; c++) begin
            if (to_sw_sig !== 2'd2 || timeout_err !== 1'b0) bad = 1'b1;
            tick(1);
        end
        n_checks++;
        if (!ok || bad) $display("FAIL notimeout_hold: sig=%0d terr=%b, want 2 0", to_sw_sig, timeout_err);
        else n_pass++;
        cpu_respond(0, 0, ok);
        n_checks++;
        if (!ok || ack_q.size() != 0)
            $display("FAIL notimeout_drain: ok=%b acks left=%0d, want 1 0", ok, ack_q.size());
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_stale_cpu();
        test_mid_reset();
        test_illegal_and_data();
`ifdef HWSW_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
